bcd_disp_scan_ctrl: RTL and testbench

//  Drives a multiplexed 7-segment display from the counter's binary value.

---
 rtl/disp_pkg.sv | 22 ++
 rtl/binary2bcd.sv | 24 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/bcd_disp_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_bcd_disp_scan_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display controller:
// segment patterns ({g,f,e,d,c,b,a}, active-high) and scan FSM states.
package disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/binary2bcd.sv
// Combinational binary to BCD converter for values up to 63 (at most two digits).
module binary2bcd #(
  parameter int NUM_BITS = 4,
  parameter int NUM_BCDS = 2
) (
  input  logic [NUM_BITS-1:0]   bin,
  output logic [4*NUM_BCDS-1:0] bcd
);

  logic [6:0] val_s;
  logic [3:0] ones_s;

  assign val_s  = 7'(bin);
  assign ones_s = 4'(val_s % 7'd10);

  if (NUM_BCDS == 2) begin : g_two
    logic [3:0] tens_s;
    assign tens_s = 4'(val_s / 7'd10);
    assign bcd    = {tens_s, ones_s};
  end else begin : g_one
    assign bcd = ones_s;
  end

endmodule

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment pattern; any non-decimal code shows a dash.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadows the counter value, converts it
// to BCD and lights one digit at a time with a blanking gap between digits.
module bcd_disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int  NUM_BITS  = 4,
  parameter int  PRESCALE  = 1000,
  parameter int  BLANK_CYC = 16,
  localparam int NUM_BCDS  = (NUM_BITS > 3) ? 2 : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                disp_en,
  input  logic                lz_en,
  input  logic [NUM_BITS-1:0] val_in,
  input  logic                val_ld,
  output logic [NUM_BCDS-1:0] dig_en,
  output logic [6:0]          seg,
  output logic                frame_done
);

  localparam int TMR_MAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic                IDX_LAST = (NUM_BCDS == 2) ? 1'b1 : 1'b0;
  localparam logic [NUM_BCDS-1:0] ONE_HOT0 = NUM_BCDS'(1);

  if (NUM_BITS < 1 || NUM_BITS > 6) begin : g_bad_bits
    $error("bcd_disp_scan_ctrl: NUM_BITS must be 1..6");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("bcd_disp_scan_ctrl: PRESCALE must be >= 2");
  end
  if (BLANK_CYC < 1) begin : g_bad_blank
    $error("bcd_disp_scan_ctrl: BLANK_CYC must be >= 1");
  end

  state_t                st_r;
  logic                  idx_r;
  logic [TMR_W-1:0]      timer_r;
  logic [NUM_BITS-1:0]   shadow_r;
  logic [NUM_BITS-1:0]   pend_val_r;
  logic                  pending_r;
  logic [4*NUM_BCDS-1:0] bcd_s;
  logic [3:0]            digit_s;
  logic [6:0]            dec_s;
  logic                  lz_blank_s;
  logic                  blank_end_s;
  logic                  show_end_s;
  logic                  boundary_s;
  logic                  idx_nxt_s;

  binary2bcd #(
    .NUM_BITS (NUM_BITS),
    .NUM_BCDS (NUM_BCDS)
  ) u_b2b (
    .bin (shadow_r),
    .bcd (bcd_s)
  );

  if (NUM_BCDS == 2) begin : g_mux
    assign digit_s    = idx_r ? bcd_s[7:4] : bcd_s[3:0];
    assign lz_blank_s = lz_en && idx_r && (digit_s == 4'd0);
  end else begin : g_single
    assign digit_s    = bcd_s;
    assign lz_blank_s = 1'b0;
  end

  seg7_decode u_dec (
    .bcd (digit_s),
    .seg (dec_s)
  );

  assign blank_end_s = (timer_r == TMR_W'(BLANK_CYC - 1));
  assign show_end_s  = (timer_r == TMR_W'(PRESCALE - 1));
  assign idx_nxt_s   = (idx_r == IDX_LAST) ? 1'b0 : (idx_r + 1'b1);
  assign boundary_s  = disp_en && (st_r == ST_SHOW) && show_end_s && (idx_r == IDX_LAST);

  // Scan FSM, shadow/pending capture and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r       <= ST_BLANK;
      idx_r      <= 1'b0;
      timer_r    <= {TMR_W{1'b0}};
      shadow_r   <= {NUM_BITS{1'b0}};
      pend_val_r <= {NUM_BITS{1'b0}};
      pending_r  <= 1'b0;
      dig_en     <= {NUM_BCDS{1'b0}};
      seg        <= 7'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!disp_en) begin
        st_r    <= ST_BLANK;
        idx_r   <= 1'b0;
        timer_r <= {TMR_W{1'b0}};
        dig_en  <= {NUM_BCDS{1'b0}};
        seg     <= 7'd0;
      end else begin
        // Outputs follow the state of this clock, so they trail it by one
        dig_en <= (st_r == ST_SHOW) ? (ONE_HOT0 << idx_r) : {NUM_BCDS{1'b0}};
        seg    <= ((st_r == ST_SHOW) && !lz_blank_s) ? dec_s : 7'd0;
        case (st_r)
          ST_BLANK: begin
            if (blank_end_s) begin
              st_r    <= ST_SHOW;
              timer_r <= {TMR_W{1'b0}};
            end else begin
              timer_r <= timer_r + TMR_W'(1);
            end
          end
          ST_SHOW: begin
            if (show_end_s) begin
              st_r       <= ST_BLANK;
              timer_r    <= {TMR_W{1'b0}};
              idx_r      <= idx_nxt_s;
              frame_done <= (idx_r == IDX_LAST);
            end else begin
              timer_r <= timer_r + TMR_W'(1);
            end
          end
          default: begin
            st_r    <= ST_BLANK;
            idx_r   <= 1'b0;
            timer_r <= {TMR_W{1'b0}};
          end
        endcase
      end

      // Shadow only moves between frames (or freely while dark) to avoid tearing
      if (!disp_en || boundary_s) begin
        if (val_ld) begin
          shadow_r <= val_in;
        end else if (pending_r) begin
          shadow_r <= pend_val_r;
        end
        pending_r <= 1'b0;
      end else if (val_ld) begin
        pending_r <= 1'b1;
      end
      if (val_ld) begin
        pend_val_r <= val_in;
      end
    end
  end

endmodule

// File: tb/tb_bcd_disp_scan_ctrl.sv
// Self-checking bench for bcd_disp_scan_ctrl (NUM_BITS=4, PRESCALE=4, BLANK_CYC=2).
module tb_bcd_disp_scan_ctrl;

  localparam int PS    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = PS + BL;
  localparam int FRAME = 2 * SLOT;

  logic       clk = 1'b0;
  logic       rst, disp_en, lz_en, val_ld;
  logic [3:0] val_in;
  logic [1:0] dig_en;
  logic [6:0] seg;
  logic       frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_disp_scan_ctrl #(
    .NUM_BITS  (4),
    .PRESCALE  (PS),
    .BLANK_CYC (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_en    (disp_en),
    .lz_en      (lz_en),
    .val_in     (val_in),
    .val_ld     (val_ld),
    .dig_en     (dig_en),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: position in frame since (re)start, plus shadow/pending
  int         m_cnt = 0;
  logic [3:0] m_sh  = 4'd0;
  logic [3:0] m_pv  = 4'd0;
  logic       m_pend = 1'b0;

  typedef struct {
    logic       r, en, lz, ld;
    logic [3:0] v;
    logic [1:0] dig;
    logic [6:0] seg;
    logic       fd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic r, en, lz, ld, input logic [3:0] v,
                       output logic [1:0] ed, output logic [6:0] es, output logic ef);
    logic upd;
    int   p, slot, digit;
    ed = 2'd0; es = 7'd0; ef = 1'b0; upd = 1'b0;
    if (r) begin
      m_cnt = 0; m_sh = 4'd0; m_pv = 4'd0; m_pend = 1'b0;
    end else begin
      if (!en) begin
        m_cnt = 0;
        upd   = 1'b1;
      end else begin
        p     = m_cnt % FRAME;
        slot  = p / SLOT;
        digit = (slot == 1) ? int'(m_sh) / 10 : int'(m_sh) % 10;
        if ((p % SLOT) >= BL) begin
          ed = (slot == 1) ? 2'b10 : 2'b01;
          es = (slot == 1 && lz && digit == 0) ? 7'd0 : lut[digit];
        end
        ef    = (p == FRAME - 1);
        upd   = ef;
        m_cnt = m_cnt + 1;
      end
      if (upd) begin
        if (ld) m_sh = v;
        else if (m_pend) m_sh = m_pv;
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      if (ld) m_pv = v;
    end
  endtask

  // One clock: drive, advance model, sample after the edge, compare
  task automatic cyc(input string nm, input logic r, en, lz, ld, input logic [3:0] v,
                     input logic use_exp, input logic [1:0] xd, input logic [6:0] xs,
                     input logic xf);
    logic [1:0] ed;
    logic [6:0] es;
    logic       ef;
    rst = r; disp_en = en; lz_en = lz; val_ld = ld; val_in = v;
    model(r, en, lz, ld, v, ed, es, ef);
    if (use_exp) begin
      ed = xd; es = xs; ef = xf;
    end
    @(posedge clk);
    #1;
    chk({nm, " dig_en"}, 8'(dig_en), 8'(ed));
    chk({nm, " seg"}, 8'(seg), 8'(es));
    chk({nm, " frame_done"}, 8'(frame_done), 8'(ef));
  endtask

  task automatic add_frame(input logic [6:0] s1, s10, input logic lz,
                           input int la, input logic [3:0] va,
                           input int lb, input logic [3:0] vb);
    vec_t e;
    for (int p = 0; p < FRAME; p++) begin
      e.r   = 1'b0;
      e.en  = 1'b1;
      e.lz  = lz;
      e.ld  = (p == la) || (p == lb);
      e.v   = (p == lb) ? vb : va;
      e.dig = ((p % SLOT) < BL) ? 2'b00 : ((p < SLOT) ? 2'b01 : 2'b10);
      e.seg = ((p % SLOT) < BL) ? 7'h00 : ((p < SLOT) ? s1 : s10);
      e.fd  = (p == FRAME - 1);
      tbl.push_back(e);
    end
  endtask

  initial begin
    vec_t e;
    rst = 1'b1; disp_en = 1'b0; lz_en = 1'b0; val_ld = 1'b0; val_in = 4'd0;

    e.r = 1'b1; e.en = 1'b0; e.lz = 1'b0; e.ld = 1'b0; e.v = 4'd0;
    e.dig = 2'b00; e.seg = 7'h00; e.fd = 1'b0;
    tbl.push_back(e);
    add_frame(7'h3F, 7'h3F, 1'b0, 0, 4'd13, -1, 4'd0);  // load 13, frame still shows 0
    add_frame(7'h4F, 7'h06, 1'b0, -1, 4'd0, -1, 4'd0);  // 13
    add_frame(7'h4F, 7'h06, 1'b1, 0, 4'd7, -1, 4'd0);   // tens 1 not suppressed
    add_frame(7'h07, 7'h00, 1'b1, -1, 4'd0, -1, 4'd0);  // 7, leading zero blanked
    add_frame(7'h07, 7'h3F, 1'b0, -1, 4'd0, -1, 4'd0);  // 7, leading zero shown
    add_frame(7'h07, 7'h3F, 1'b0, 3, 4'd5, 8, 4'd9);    // 5 then 9 pending
    add_frame(7'h6F, 7'h3F, 1'b0, 11, 4'd12, -1, 4'd0); // 9; load on boundary clock
    add_frame(7'h5B, 7'h06, 1'b0, -1, 4'd0, -1, 4'd0);  // 12 applied immediately

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].en, tbl[i].lz, tbl[i].ld, tbl[i].v,
          1'b1, tbl[i].dig, tbl[i].seg, tbl[i].fd);
    end

    // disp_en dropped mid-SHOW, then re-enabled
    cyc("den_p0", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("den_p1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("den_p2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b01, 7'h5B, 1'b0);
    cyc("den_p3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b01, 7'h5B, 1'b0);
    cyc("den_off", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("den_off2", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("den_re0", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("den_re1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("den_re2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b01, 7'h5B, 1'b0);
    cyc("den_re3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b01, 7'h5B, 1'b0);

    // rst mid-SHOW with shadow 12
    cyc("rst_pre", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b01, 7'h5B, 1'b0);
    cyc("rst_hit", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("rst_p0", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("rst_p1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 7'h00, 1'b0);
    cyc("rst_p2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b01, 7'h3F, 1'b0);
    cyc("rst_p3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 2'b01, 7'h3F, 1'b0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      cyc($sformatf("rnd%0d", i),
          ($urandom_range(0, 299) == 0),
          ($urandom_range(0, 39) != 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0),
          4'($urandom_range(0, 15)),
          1'b0, 2'b00, 7'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
